lsu_controller: RTL and testbench

- Sequences one load or store at a time between the execute stage and the single-port data memory bus.
- Takes the address, lane-replicated store data and byte mask produced by the store address/data helper.
- Checks alignment, drives a held request/ready handshake to memory, and enforces a timeout.
- On loads, extracts and sign- or zero-extends the addressed lane, then returns a one-cycle response to the core.

---
 rtl/lsu_controller.sv | 144 ++++++++++++++
 tb/tb_lsu_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
// Load/store unit controller: sequences one access at a time to a single-port
// data memory, with alignment checks, a request timeout and load extension.
module lsu_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        legal;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext;

   always_comb begin
      legal = 1'b0;
      if (req_is_store) begin
         case (req_funct3)
            3'b000:  legal = (req_wmask != '0);
            3'b001:  legal = (req_wmask != '0) && !req_addr[0];
            3'b010:  legal = (req_wmask != '0) && (req_addr[1:0] == 2'b00);
            default: legal = 1'b0;
         endcase
      end else begin
         case (req_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = !req_addr[0];
            3'b010:         legal = (req_addr[1:0] == 2'b00);
            default:        legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (off_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ext = {24'd0, byte_sel};
         3'b001:  ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  ext = {16'd0, half_sel};
         default: ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
         cnt        <= '0;
         f3_q       <= '0;
         off_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  f3_q      <= req_funct3;
                  off_q     <= req_addr[1:0];
                  cnt       <= '0;
                  if (legal) begin
                     state     <= ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= req_is_store;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= req_is_store ? req_wdata : '0;
                     mem_wmask <= req_is_store ? req_wmask : '0;
                  end else begin
                     // Illegal requests respond directly without touching memory
                     state      <= ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= mem_we ? '0 : ext;
               end else if (cnt == TO_LAST) begin
                  state      <= ERR;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP, ERR: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller built with a short timeout so that the
// timeout and ready-on-last-cycle paths are reachable in a few cycles.
module tb_lsu_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wmask = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   // Presents one request for a single cycle; returns at the sample point of
   // the first cycle after the accept edge.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm);
      @(negedge clk);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_addr = a; req_wdata = wd; req_wmask = wm;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask}
          !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
         bad++;
         $display("FAIL reset: rdy=%b rv=%b err=%b rd=%h req=%b we=%b a=%h wd=%h wm=%b",
                  req_ready, resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
      end
      rst = 1'b0;
   endtask

   task automatic test_store();
      issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111);
      mem_ready = 1'b1;
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, req_ready, resp_valid}
          !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL sw_access: req=%b we=%b a=%h wd=%h wm=%b rdy=%b rv=%b, want 1 1 100 deadbeef 1111 0 0",
                  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, req_ready, resp_valid);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      total++;
      if ({resp_valid, resp_err, resp_rdata, mem_req, req_ready} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL sw_resp: rv=%b err=%b rd=%h req=%b rdy=%b, want 1 0 0 0 0",
                  resp_valid, resp_err, resp_rdata, mem_req, req_ready);
      end
      @(negedge clk);
      total++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL sw_idle: rv=%b rdy=%b, want 0 1", resp_valid, req_ready);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      logic [31:0] addrs [6] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h204, 32'h201};
      logic [31:0] words [6] = '{32'h80FF1234, 32'h80FF1234, 32'h80017FFF, 32'h80017FFF,
                                 32'h12345678, 32'h80FF1234};
      int          waits [6] = '{3, 3, 0, 0, 1, 0};
      logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00007FFF,
                                 32'h12345678, 32'h00000012};
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, f3s[i], addrs[i], 32'hFFFFFFFF, 4'b1111);
         mem_rdata = words[i];
         for (int w = 0; w <= waits[i]; w++) begin
            if (w == waits[i]) mem_ready = 1'b1;
            total++;
            if ({mem_req, mem_we, mem_wmask, mem_addr, resp_valid}
                !== {1'b1, 1'b0, 4'b0000, addrs[i] & 32'hFFFFFFFC, 1'b0}) begin
               bad++;
               $display("FAIL load%0d_access cyc%0d: req=%b we=%b wm=%b a=%h rv=%b, want 1 0 0000 %h 0",
                        i, w, mem_req, mem_we, mem_wmask, mem_addr, resp_valid, addrs[i] & 32'hFFFFFFFC);
            end
            @(negedge clk);
         end
         mem_ready = 1'b0;
         mem_rdata = '0;
         total++;
         if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b0, exps[i], 1'b0}) begin
            bad++;
            $display("FAIL load%0d_resp: rv=%b err=%b rd=%h req=%b, want 1 0 %h 0",
                     i, resp_valid, resp_err, resp_rdata, mem_req, exps[i]);
         end
         @(negedge clk);
         total++;
         if ({resp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL load%0d_idle: rv=%b rdy=%b, want 0 1", i, resp_valid, req_ready);
         end
      end
   endtask

   task automatic test_illegal();
      logic        sts   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s   [6] = '{3'b010, 3'b001, 3'b011, 3'b000, 3'b011, 3'b110};
      logic [31:0] addrs [6] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h100, 32'h100};
      logic [3:0]  masks [6] = '{4'b0000, 4'b0011, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 6; i++) begin
         issue(sts[i], f3s[i], addrs[i], 32'hA5A5A5A5, masks[i]);
         total++;
         if ({mem_req, resp_valid, resp_err, resp_rdata, req_ready}
             !== {1'b0, 1'b1, 1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL illegal%0d_resp: req=%b rv=%b err=%b rd=%h rdy=%b, want 0 1 1 0 0",
                     i, mem_req, resp_valid, resp_err, resp_rdata, req_ready);
         end
         @(negedge clk);
         total++;
         if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
            bad++;
            $display("FAIL illegal%0d_idle: req=%b rv=%b rdy=%b, want 0 0 1",
                     i, mem_req, resp_valid, req_ready);
         end
      end
   endtask

   task automatic test_timeout();
      issue(1'b0, 3'b010, 32'h300, 32'h0, 4'b0000);
      for (int c = 0; c < 4; c++) begin
         total++;
         if ({mem_req, mem_addr, resp_valid} !== {1'b1, 32'h300, 1'b0}) begin
            bad++;
            $display("FAIL timeout_access cyc%0d: req=%b a=%h rv=%b, want 1 300 0",
                     c, mem_req, mem_addr, resp_valid);
         end
         @(negedge clk);
      end
      total++;
      if ({mem_req, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
         bad++;
         $display("FAIL timeout_resp: req=%b rv=%b err=%b rd=%h, want 0 1 1 0",
                  mem_req, resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
      total++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL timeout_idle: rv=%b rdy=%b, want 0 1", resp_valid, req_ready);
      end
      // ready arrives in the last allowed cycle and must win over the timeout
      issue(1'b0, 3'b010, 32'h300, 32'h0, 4'b0000);
      mem_rdata = 32'hCAFEF00D;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) mem_ready = 1'b1;
         total++;
         if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL lastcycle_access cyc%0d: req=%b, want 1", c, mem_req);
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      total++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
         bad++;
         $display("FAIL lastcycle_resp: rv=%b err=%b rd=%h, want 1 0 cafef00d",
                  resp_valid, resp_err, resp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 3'b010, 32'h100, 32'h11223344, 4'b1111);
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_access: req=%b, want 1", mem_req);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({mem_req, req_ready, resp_valid} !== 3'b010) begin
         bad++;
         $display("FAIL rstmid_kill: req=%b rdy=%b rv=%b, want 0 1 0", mem_req, req_ready, resp_valid);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_req, req_ready, resp_valid} !== 3'b010) begin
         bad++;
         $display("FAIL rstmid_after: req=%b rdy=%b rv=%b, want 0 1 0", mem_req, req_ready, resp_valid);
      end
      test_store();
   endtask

   initial begin
      test_reset();
      test_store();
      test_loads();
      test_illegal();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
